// File: rtl/cpx_accumulate_if.sv
// Sample-in / sum-out bundle for the complex integrate-and-dump stage.
// The slave side is the accumulator; the master side feeds samples and drains sums.
interface cpx_accumulate_if #(
  parameter int i_bits     = 16,
  parameter int q_bits     = 16,
  parameter int length     = 16,
  parameter int cnt_bits   = $clog2(length + 1),
  parameter int acc_i_bits = i_bits + $clog2(length),
  parameter int acc_q_bits = q_bits + $clog2(length)
);
  logic                         m_axis_tvalid;
  logic                         s_axis_tready;
  logic signed [i_bits-1:0]     i_in;
  logic signed [q_bits-1:0]     q_in;
  logic                         m_axis_tlast;
  logic                         s_axis_tvalid;
  logic                         m_axis_tready;
  logic signed [acc_i_bits-1:0] acc_i_out;
  logic signed [acc_q_bits-1:0] acc_q_out;
  logic        [cnt_bits-1:0]   n_out;
  logic                         s_axis_tlast;

  modport slave (
    input  m_axis_tvalid, i_in, q_in, m_axis_tlast, m_axis_tready,
    output s_axis_tready, s_axis_tvalid, acc_i_out, acc_q_out, n_out, s_axis_tlast
  );

  modport master (
    output m_axis_tvalid, i_in, q_in, m_axis_tlast, m_axis_tready,
    input  s_axis_tready, s_axis_tvalid, acc_i_out, acc_q_out, n_out, s_axis_tlast
  );
endinterface

// File: rtl/cpx_accumulate.sv
// Integrate-and-dump of complex products; result valid 1 cycle after the closing sample is accepted.
// Backpressure: s_axis_tready drops only when another block would close over an unconsumed result.
module cpx_accumulate #(
  parameter int i_bits     = 16,
  parameter int q_bits     = 16,
  parameter int length     = 16,
  parameter int cnt_bits   = $clog2(length + 1),
  parameter int acc_i_bits = i_bits + $clog2(length),
  parameter int acc_q_bits = q_bits + $clog2(length)
) (
  input  logic            clk,
  input  logic            rst_n,
  cpx_accumulate_if.slave cpx
);
  localparam logic [cnt_bits-1:0] LAST_CNT = cnt_bits'(length - 1);

  if (length < 2 || length > 1024) begin : g_bad_length
    $error("cpx_accumulate: length must be in 2..1024");
  end

  logic        [cnt_bits-1:0]   count;
  logic signed [acc_i_bits-1:0] acc_i;
  logic signed [acc_q_bits-1:0] acc_q;
  logic signed [acc_i_bits-1:0] ext_i;
  logic signed [acc_q_bits-1:0] ext_q;
  logic signed [acc_i_bits-1:0] sum_i;
  logic signed [acc_q_bits-1:0] sum_q;
  logic                         last_slot;
  logic                         accept;
  logic                         close;

  // Only a closing accept can collide with a pending result, so only that case stalls.
  assign last_slot         = (count == LAST_CNT) || cpx.m_axis_tlast;
  assign cpx.s_axis_tready = !(cpx.s_axis_tvalid && !cpx.m_axis_tready && last_slot);
  assign accept            = cpx.m_axis_tvalid && cpx.s_axis_tready;
  assign close             = accept && last_slot;

  always_comb begin
    ext_i = {{(acc_i_bits - i_bits){cpx.i_in[i_bits-1]}}, cpx.i_in};
    ext_q = {{(acc_q_bits - q_bits){cpx.q_in[q_bits-1]}}, cpx.q_in};
    // First sample of a block loads directly, so no clear cycle is needed between blocks.
    sum_i = (count == '0) ? ext_i : acc_i + ext_i;
    sum_q = (count == '0) ? ext_q : acc_q + ext_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count             <= '0;
      acc_i             <= '0;
      acc_q             <= '0;
      cpx.acc_i_out     <= '0;
      cpx.acc_q_out     <= '0;
      cpx.n_out         <= '0;
      cpx.s_axis_tvalid <= 1'b0;
      cpx.s_axis_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        acc_i <= sum_i;
        acc_q <= sum_q;
        count <= close ? '0 : count + cnt_bits'(1);
      end
      if (close) begin
        cpx.acc_i_out     <= sum_i;
        cpx.acc_q_out     <= sum_q;
        cpx.n_out         <= count + cnt_bits'(1);
        cpx.s_axis_tlast  <= cpx.m_axis_tlast;
        cpx.s_axis_tvalid <= 1'b1;
      end else if (cpx.s_axis_tvalid && cpx.m_axis_tready) begin
        cpx.s_axis_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_cpx_accumulate.sv
// Randomised and directed checks of cpx_accumulate against a sample-level block-sum model.
module tb_cpx_accumulate;
  localparam int LEN4  = 4;
  localparam int LEN16 = 16;
  localparam int N_RAND = 1000;

  typedef struct {
    longint i;
    longint q;
    int     n;
    bit     last;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpx_accumulate_if #(.length(LEN4))  b4  ();
  cpx_accumulate_if #(.length(LEN16)) b16 ();

  cpx_accumulate #(.length(LEN4))  u_len4  (.clk(clk), .rst_n(rst_n), .cpx(b4));
  cpx_accumulate #(.length(LEN16)) u_len16 (.clk(clk), .rst_n(rst_n), .cpx(b16));

  int     n_chk  = 0;
  int     n_fail = 0;
  res_t   exp4[$];
  res_t   exp16[$];
  longint m_sum_i[2];
  longint m_sum_q[2];
  int     m_n[2];
  int     n_exp[2];
  int     n_seen[2];
  int     n_acc[2];
  int     len_of[2];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: running block sum closed at length samples or on tlast.
  task automatic model_push(input int s, input longint i, input longint q, input bit last);
    res_t r;
    n_acc[s]++;
    m_sum_i[s] += i;
    m_sum_q[s] += q;
    m_n[s]++;
    if (m_n[s] == len_of[s] || last) begin
      r.i = m_sum_i[s]; r.q = m_sum_q[s]; r.n = m_n[s]; r.last = last;
      if (s == 0) exp4.push_back(r); else exp16.push_back(r);
      n_exp[s]++;
      m_sum_i[s] = 0; m_sum_q[s] = 0; m_n[s] = 0;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_sum_i[s] = 0; m_sum_q[s] = 0; m_n[s] = 0;
    end
    exp4.delete();
    exp16.delete();
  endtask

  task automatic check_out(input int s, input longint i, input longint q,
                           input longint n, input bit last);
    res_t r;
    n_seen[s]++;
    if ((s == 0 && exp4.size() == 0) || (s == 1 && exp16.size() == 0)) begin
      chk($sformatf("unexpected_result_len%0d", len_of[s]), 1, 0);
    end else begin
      r = (s == 0) ? exp4.pop_front() : exp16.pop_front();
      chk($sformatf("sum_i_len%0d", len_of[s]), i, r.i);
      chk($sformatf("sum_q_len%0d", len_of[s]), q, r.q);
      chk($sformatf("n_out_len%0d", len_of[s]), n, r.n);
      chk($sformatf("tlast_len%0d", len_of[s]), last, r.last);
    end
  endtask

  // Inputs change just after posedge, so a negedge sample sees what the next edge will act on.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (b4.s_axis_tvalid && b4.m_axis_tready)
        check_out(0, b4.acc_i_out, b4.acc_q_out, b4.n_out, b4.s_axis_tlast);
      if (b16.s_axis_tvalid && b16.m_axis_tready)
        check_out(1, b16.acc_i_out, b16.acc_q_out, b16.n_out, b16.s_axis_tlast);
    end
  end

  task automatic idle(input int s);
    if (s == 0) begin b4.m_axis_tvalid = 1'b0; b4.m_axis_tlast = 1'b0; end
    else begin b16.m_axis_tvalid = 1'b0; b16.m_axis_tlast = 1'b0; end
  endtask

  // Holds the sample until accepted; returns just after the accepting edge.
  task automatic send(input int s, input longint i, input longint q, input bit last);
    bit rdy;
    int w;
    if (s == 0) begin
      b4.m_axis_tvalid = 1'b1; b4.i_in = 16'(i); b4.q_in = 16'(q); b4.m_axis_tlast = last;
    end else begin
      b16.m_axis_tvalid = 1'b1; b16.i_in = 16'(i); b16.q_in = 16'(q); b16.m_axis_tlast = last;
    end
    w = 0;
    do begin
      @(negedge clk);
      rdy = (s == 0) ? b4.s_axis_tready : b16.s_axis_tready;
      @(posedge clk);
      #1;
      w++;
    end while (!rdy && w < 100);
    if (!rdy) chk("send_timeout", 0, 1);
    else model_push(s, i, q, last);
  endtask

  initial begin
    assert (LEN4 > 1 && LEN16 > 1) else $fatal(1, "FAIL length_legal: length must be at least 2");
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_start;
    bit done;
    len_of[0] = LEN4;
    len_of[1] = LEN16;
    for (int s = 0; s < 2; s++) begin
      n_exp[s] = 0; n_seen[s] = 0; n_acc[s] = 0;
    end
    model_reset();
    rst_n = 1'b0;
    b4.i_in = '0;  b4.q_in = '0;  b4.m_axis_tready = 1'b1;
    b16.i_in = '0; b16.q_in = '0; b16.m_axis_tready = 1'b1;
    idle(0);
    idle(1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_valid", b4.s_axis_tvalid, 0);
    chk("rst_acc_i", b4.acc_i_out, 0);
    chk("rst_acc_q", b4.acc_q_out, 0);
    chk("rst_n_out", b4.n_out, 0);
    chk("rst_tlast", b4.s_axis_tlast, 0);
    chk("rst_ready", b4.s_axis_tready, 1);
    chk("rst_ready16", b16.s_axis_tready, 1);
    @(posedge clk);
    #1;

    // Basic block of four, single-cycle result pulse
    for (int k = 1; k <= 4; k++) send(0, k, -k, 0);
    idle(0);
    @(negedge clk);
    chk("basic_valid", b4.s_axis_tvalid, 1);
    chk("basic_acc_i", b4.acc_i_out, 10);
    chk("basic_acc_q", b4.acc_q_out, -10);
    chk("basic_n_out", b4.n_out, 4);
    chk("basic_tlast", b4.s_axis_tlast, 0);
    @(negedge clk);
    chk("basic_pulse_1cyc", b4.s_axis_tvalid, 0);
    @(posedge clk);
    #1;

    // Most-negative inputs must not wrap
    for (int k = 0; k < 4; k++) send(0, -32768, -32768, 0);
    idle(0);
    @(negedge clk);
    chk("minneg_acc_i", b4.acc_i_out, -131072);
    chk("minneg_acc_q", b4.acc_q_out, -131072);
    @(posedge clk);
    #1;

    // Downstream stalled across two blocks
    b4.m_axis_tready = 1'b0;
    acc_start = n_acc[0];
    fork
      begin
        for (int k = 0; k < 8; k++) send(0, 1, 1, 0);
        idle(0);
      end
      begin
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("stall_ready", b4.s_axis_tready, 0);
        chk("stall_valid", b4.s_axis_tvalid, 1);
        chk("stall_hold_i", b4.acc_i_out, 4);
        chk("stall_accepts", n_acc[0] - acc_start, 7);
        @(posedge clk);
        #1 b4.m_axis_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Short block closed by tlast, then a normal block from count 0
    send(0, 5, 0, 0);
    send(0, 7, 0, 1);
    idle(0);
    @(negedge clk);
    chk("short_valid", b4.s_axis_tvalid, 1);
    chk("short_acc_i", b4.acc_i_out, 12);
    chk("short_acc_q", b4.acc_q_out, 0);
    chk("short_n_out", b4.n_out, 2);
    chk("short_tlast", b4.s_axis_tlast, 1);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) send(0, 1, 1, 0);
    idle(0);
    repeat (3) @(posedge clk);
    #1;

    // Random stream with random gaps and random downstream readiness
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < N_RAND; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            idle(1);
            @(posedge clk);
            #1;
          end
          send(1, longint'($urandom_range(0, 65535)) - 32768,
               longint'($urandom_range(0, 65535)) - 32768, k == N_RAND - 1);
        end
        idle(1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 b16.m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    b16.m_axis_tready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_results", n_seen[1], (N_RAND + LEN16 - 1) / LEN16);
    chk("rand_drained", exp16.size(), 0);

    // Reset mid-block discards the partial sum
    send(0, 9, 9, 0);
    send(0, 9, 9, 0);
    idle(0);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) send(0, 1, 1, 0);
    idle(0);
    @(negedge clk);
    chk("rst_mid_acc_i", b4.acc_i_out, 4);
    chk("rst_mid_n_out", b4.n_out, 4);
    repeat (3) @(posedge clk);
    #1;

    chk("len4_drained", exp4.size(), 0);
    chk("len4_count", n_seen[0], n_exp[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
